// File: rtl/life_pkg.sv
// life_pkg: shared constants and state encoding for the Game of Life generation sequencer
package life_pkg;
  localparam int ROWS = 30;
  localparam int COLS = 40;
  localparam int ADDR_W = 5;
  localparam int GEN_W = 16;
  localparam int LIVE_MIN = 2;
  localparam int LIVE_MAX = 3;
  localparam int BIRTH = 3;
  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_READ,
    S_LOAD,
    S_WRITE,
    S_YIELD,
    S_DONE
  } state_t;
endpackage

// File: rtl/life_row_eval.sv
// life_row_eval: next-generation value of one board row from its three-row neighbourhood
module life_row_eval
  import life_pkg::*;
(
  input  logic [COLS-1:0] above,
  input  logic [COLS-1:0] cur,
  input  logic [COLS-1:0] below,
  output logic [COLS-1:0] next
);
  logic [COLS-1:0] a_lo, a_hi, c_lo, c_hi, b_lo, b_hi;
  assign a_lo = above << 1;
  assign a_hi = above >> 1;
  assign c_lo = cur << 1;
  assign c_hi = cur >> 1;
  assign b_lo = below << 1;
  assign b_hi = below >> 1;
  for (genvar i = 0; i < COLS; i++) begin : g_col
    logic [3:0] n;
    assign n = 4'(a_lo[i]) + 4'(above[i]) + 4'(a_hi[i]) + 4'(c_lo[i]) + 4'(c_hi[i])
             + 4'(b_lo[i]) + 4'(below[i]) + 4'(b_hi[i]);
    assign next[i] = cur[i] ? (n >= 4'(LIVE_MIN) && n <= 4'(LIVE_MAX)) : (n == 4'(BIRTH));
  end
endmodule

// File: rtl/life_gen_sequencer.sv
// life_gen_sequencer: in-place generation sweep over the board RAM, yielding the port to the draw scanner between rows
module life_gen_sequencer
  import life_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              draw_req,
  output logic              draw_gnt,
  output logic              busy,
  output logic              done,
  output logic [GEN_W-1:0]  gen_count,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [COLS-1:0]   ram_wdata,
  output logic              ram_wren,
  input  logic [COLS-1:0]   ram_q
);
  state_t state;
  logic [ADDR_W-1:0] r;
  logic [COLS-1:0] above, cur, below, next;
  logic pend, last;
  assign last = r == ADDR_W'(ROWS - 1);
  life_row_eval u_eval (
    .above(above),
    .cur(cur),
    .below(below),
    .next(next)
  );
  // RAM port and handshake outputs decoded from the current state
  always_comb begin
    draw_gnt = !reset && draw_req && (state == S_IDLE || state == S_YIELD);
    busy = state != S_IDLE;
    done = state == S_DONE;
    ram_wren = state == S_WRITE;
    ram_wdata = ram_wren ? next : '0;
    ram_addr = state == S_READ ? (last ? '0 : r + 1'b1) : state == S_WRITE ? r : '0;
  end
  // Row sweep: prime row 0, then read-ahead / load / write-back per row with a sliding window
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      r <= '0;
      above <= '0;
      cur <= '0;
      below <= '0;
      pend <= 1'b0;
      gen_count <= '0;
    end else
      case (state)
        S_IDLE:
          if ((start || pend) && !draw_req) begin
            r <= '0;
            above <= '0;
            pend <= 1'b0;
            state <= S_PRIME;
          end else if (start) pend <= 1'b1;
        S_PRIME: state <= S_READ;
        S_READ: begin
          if (r == '0) cur <= ram_q;
          state <= S_LOAD;
        end
        S_LOAD: begin
          below <= last ? '0 : ram_q;
          state <= S_WRITE;
        end
        S_WRITE: begin
          above <= cur;
          cur <= below;
          r <= r + 1'b1;
          state <= last ? S_DONE : draw_req ? S_YIELD : S_READ;
        end
        S_YIELD: if (!draw_req) state <= S_READ;
        S_DONE: begin
          gen_count <= gen_count + 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
endmodule
